// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package instruction_fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   // One buffered fetch: the instruction word together with its PC.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Entry 0 is always the head, so the
// head is a plain register and reads out with no extra mux or read latency.
module fetch_fifo
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     entries      [DEPTH];
   fetch_entry_t     entries_next [DEPTH];
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] wr_idx;

   // Next contents: shift down on pop, write behind the last live entry on push.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) entries_next[i] = entries[i];
      count_next = count;
      wr_idx     = pop ? count - CNT_W'(1) : count;
      if (flush) begin
         count_next = '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) entries_next[i] = entries[i + 1];
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (i == int'(wr_idx))) entries_next[i] = push_data;
         end
         count_next = count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage and occupancy registers; data is cleared too so the head reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         count <= count_next;
         for (int i = 0; i < DEPTH; i++) entries[i] <= entries_next[i];
      end
   end

   assign head = entries[0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order word fetches, buffers responses with their PCs
// and hands them to decode. A redirect flushes the buffer and marks every
// in-flight fetch to be dropped when it returns.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  resp_pc;
   logic [XLEN-1:0]  target_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_after;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W:0]   credit_used;
   logic             grant;
   logic             push;
   logic             pop;
   logic             redirect_lsb_unused;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   // Byte offset of a redirect target is meaningless for word fetches.
   assign redirect_lsb_unused = ^redirect_pc[1:0];
   assign target_pc           = {redirect_pc[31:2], 2'b00};

   assign pop         = instr_valid & instr_ready;
   assign grant       = imem_req & imem_gnt;
   assign push        = imem_rvalid & (discard == '0) & ~redirect_valid;
   assign push_entry  = '{pc: resp_pc, instr: imem_rdata};

   // A slot being drained by decode this cycle is free for a new request;
   // without that, one fetch slot would idle every other cycle at depth 2.
   assign credit_used = {1'b0, outstanding} + {1'b0, occupancy} - (CNT_W + 1)'(pop);

   // Issue whenever a buffer slot is guaranteed for the response; never during redirect or reset.
   always_comb begin
      imem_req = rst_n & ~redirect_valid & (credit_used < (CNT_W + 1)'(DEPTH));
   end

   assign imem_addr         = fetch_pc;
   assign outstanding_after = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);

   // Track fetches in flight and how many of them belong to a flushed path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_after;
         if (redirect_valid) begin
            discard <= outstanding_after;
         end else if (imem_rvalid && (discard != '0)) begin
            discard <= discard - CNT_W'(1);
         end
      end
   end

   // Request PC advances on grant, response PC on each kept response; redirect reloads both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= target_pc;
         resp_pc  <= target_pc;
      end else begin
         if (grant) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
         if (push)  resp_pc  <= resp_pc + XLEN'(INSTR_BYTES);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (occupancy),
      .head      (head)
   );

   assign instr_valid = (occupancy != '0);
   assign instruction = head.instr;
   assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a fixed-latency in-order memory model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int lat      = 1;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mq[$];

   always #5 clk = ~clk;

   instruction_fetch #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc)
   );

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] idata(input logic [31:0] a);
      return a ^ 32'h5EED_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int max_cyc, input string tag);
      int n;
      n = 0;
      while (!instr_valid && n < max_cyc) begin
         next();
         smp();
         n++;
      end
      check({tag, "_timeout"}, {31'b0, instr_valid}, 32'd1);
   endtask

   // In-order memory: grants recorded mid-cycle, response driven lat cycles later.
   initial begin : mem_model
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = idata(mq[0].addr);
            mq.delete(0);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end
         @(negedge clk);
         if (!rst_n) mq.delete();
         else if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: cyc + lat});
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst_n          = 1'b0;
      imem_gnt       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b1;

      // Reset values
      @(posedge clk);
      smp();
      check("rst_req",   {31'b0, imem_req},    32'd0);
      check("rst_addr",  imem_addr,            32'h0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instruction,          32'h0);
      check("rst_pc",    instr_pc,             32'h0);

      // Sequential fetch, latency 1, decode always ready
      lat = 1; instr_ready = 1'b1;
      do_reset();
      smp();
      check("seq_c0_req",  {31'b0, imem_req}, 32'd1);
      check("seq_c0_addr", imem_addr,         32'h0);
      next(); smp();
      check("seq_c1_valid", {31'b0, instr_valid}, 32'd0);
      next(); smp();
      check("seq_c2_valid", {31'b0, instr_valid}, 32'd1);
      check("seq_c2_pc",    instr_pc,             32'h0);
      check("seq_c2_instr", instruction,          idata(32'h0));
      for (int k = 1; k < 4; k++) begin
         next(); smp();
         check("seq_valid", {31'b0, instr_valid}, 32'd1);
         check("seq_pc",    instr_pc,             32'(4 * k));
         check("seq_instr", instruction,          idata(32'(4 * k)));
      end

      // Decode backpressure
      lat = 1; instr_ready = 1'b0;
      do_reset();
      next(); next(); smp();
      check("bp_c2_req",   {31'b0, imem_req},    32'd0);
      check("bp_c2_valid", {31'b0, instr_valid}, 32'd1);
      next(); smp();
      check("bp_c3_req", {31'b0, imem_req}, 32'd0);
      check("bp_c3_pc",  instr_pc,          32'h0);
      next(); smp();
      check("bp_c4_pc",    instr_pc,    32'h0);
      check("bp_c4_instr", instruction, idata(32'h0));
      next(); instr_ready = 1'b1; smp();
      check("bp_c5_pc", instr_pc, 32'h0);
      next(); smp();
      check("bp_c6_pc", instr_pc, 32'h4);
      next(); smp();
      check("bp_c7_pc",    instr_pc,    32'h8);
      check("bp_c7_instr", instruction, idata(32'h8));

      // Redirect with two fetches in flight, latency 3
      lat = 3; instr_ready = 1'b1;
      do_reset();
      next(); next();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      smp();
      check("rd3_req_forced", {31'b0, imem_req}, 32'd0);
      next(); redirect_valid = 1'b0; smp();
      check("rd3_c3_valid", {31'b0, instr_valid}, 32'd0);
      next(); smp();
      check("rd3_c4_valid", {31'b0, instr_valid}, 32'd0);
      wait_valid(12, "rd3");
      check("rd3_first_pc",    instr_pc,    32'h100);
      check("rd3_first_instr", instruction, idata(32'h100));
      next(); smp();
      check("rd3_second_pc", instr_pc, 32'h104);

      // Misaligned redirect coinciding with a handshake and a returning response
      lat = 1; instr_ready = 1'b1;
      do_reset();
      next(); next();
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      smp();
      check("mis_req_forced", {31'b0, imem_req}, 32'd0);
      check("mis_hs_pc",      instr_pc,          32'h0);
      next(); redirect_valid = 1'b0; smp();
      check("mis_addr",  imem_addr,            32'h100);
      check("mis_req",   {31'b0, imem_req},    32'd1);
      check("mis_valid", {31'b0, instr_valid}, 32'd0);
      next(); smp();
      check("mis_c4_valid", {31'b0, instr_valid}, 32'd0);
      next(); smp();
      check("mis_first_pc",    instr_pc,    32'h100);
      check("mis_first_instr", instruction, idata(32'h100));
      next(); smp();
      check("mis_second_pc", instr_pc, 32'h104);

      // Redirect with handshake, grant asserted and one earlier fetch outstanding
      lat = 2; instr_ready = 1'b1;
      do_reset();
      next(); next(); next(); smp();
      check("hs_c3_pc", instr_pc, 32'h0);
      next();
      redirect_valid = 1'b1; redirect_pc = 32'h200; imem_gnt = 1'b1;
      smp();
      check("hs_c4_pc",    instr_pc,             32'h4);
      check("hs_c4_valid", {31'b0, instr_valid}, 32'd1);
      check("hs_c4_req",   {31'b0, imem_req},    32'd0);
      next(); redirect_valid = 1'b0; smp();
      check("hs_c5_valid", {31'b0, instr_valid}, 32'd0);
      check("hs_c5_addr",  imem_addr,            32'h200);
      check("hs_c5_req",   {31'b0, imem_req},    32'd1);
      wait_valid(12, "hs");
      check("hs_first_pc",  instr_pc, 32'h200);
      next(); smp();
      check("hs_second_pc", instr_pc, 32'h204);

      // Mid-run reset with the FIFO full
      lat = 1; instr_ready = 1'b0;
      do_reset();
      next(); next(); next(); next(); smp();
      check("mr_full_valid", {31'b0, instr_valid}, 32'd1);
      next(); rst_n = 1'b0; smp();
      check("mr_valid", {31'b0, instr_valid}, 32'd0);
      check("mr_req",   {31'b0, imem_req},    32'd0);
      check("mr_pc",    instr_pc,             32'h0);
      next(); rst_n = 1'b1; instr_ready = 1'b1; smp();
      check("mr_c0_req",  {31'b0, imem_req}, 32'd1);
      check("mr_c0_addr", imem_addr,         32'h0);
      next(); next(); smp();
      check("mr_c2_valid", {31'b0, instr_valid}, 32'd1);
      check("mr_c2_pc",    instr_pc,             32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
